// File: rtl/prbs_pkg.sv
// Shared definitions for the multi-polynomial PRBS generator: mode codes, tap and
// length tables, and seed sanitising.
package prbs_pkg;

  localparam logic [2:0] MODE_PRBS7  = 3'd0;
  localparam logic [2:0] MODE_PRBS9  = 3'd1;
  localparam logic [2:0] MODE_PRBS15 = 3'd2;
  localparam logic [2:0] MODE_PRBS23 = 3'd3;
  localparam logic [2:0] MODE_PRBS31 = 3'd4;

  localparam int unsigned MAX_LEN = 31;

  typedef logic [MAX_LEN-1:0] prbs_state_t;

  // Codes above PRBS31 have no polynomial and fall back to PRBS7.
  function automatic logic [2:0] prbs_mode_fix(logic [2:0] mode);
    return (mode > MODE_PRBS31) ? MODE_PRBS7 : mode;
  endfunction

  function automatic int unsigned prbs_len(logic [2:0] mode);
    case (mode)
      MODE_PRBS9:  return 9;
      MODE_PRBS15: return 15;
      MODE_PRBS23: return 23;
      MODE_PRBS31: return 31;
      default:     return 7;
    endcase
  endfunction

  // Tap mask with bits (a-1) and (b-1) set; the feedback bit is the XOR of the masked state.
  function automatic prbs_state_t prbs_taps(logic [2:0] mode);
    case (mode)
      MODE_PRBS9:  return 31'h0000_0110;
      MODE_PRBS15: return 31'h0000_6000;
      MODE_PRBS23: return 31'h0042_0000;
      MODE_PRBS31: return 31'h4800_0000;
      default:     return 31'h0000_0060;
    endcase
  endfunction

  function automatic prbs_state_t prbs_mask(logic [2:0] mode);
    logic [63:0] m;
    m = (64'd1 << prbs_len(mode)) - 64'd1;
    return m[MAX_LEN-1:0];
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by all ones.
  function automatic prbs_state_t prbs_seed(prbs_state_t seed, logic [2:0] mode);
    prbs_state_t s;
    s = seed & prbs_mask(mode);
    return (s == '0) ? prbs_mask(mode) : s;
  endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Combinational W-step unroll of the Fibonacci LFSR for the selected polynomial.
module prbs_lfsr_core
  import prbs_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  prbs_state_t  state,
  input  logic [2:0]   mode,
  output prbs_state_t  state_next,
  output logic [W-1:0] word
);

  prbs_state_t taps;
  prbs_state_t mask;
  prbs_state_t s;
  logic        nb;

  always_comb begin
    taps = prbs_taps(mode);
    mask = prbs_mask(mode);
    s    = state;
    nb   = 1'b0;
    word = '0;
    for (int unsigned k = 0; k < W; k++) begin
      nb      = ^(s & taps);
      word[k] = nb;
      s       = {s[MAX_LEN-2:0], nb} & mask;
    end
    state_next = s;
  end

endmodule

// File: rtl/prbs_gen.sv
// Multi-polynomial PRBS source with valid/ready output, seed load and zero-lock protection.
// Define PRBS_ERR_INJECT_EN to add inj_i, which flips bit 0 of one generated word.
module prbs_gen
  import prbs_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter logic [2:0]  DEF_MODE = 3'd0,
  parameter logic [30:0] DEF_SEED = 31'h7FFF_FFFF,
  parameter bit          INVERT   = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
`ifdef PRBS_ERR_INJECT_EN
  input  logic         inj_i,
`endif
  input  logic         en_i,
  input  logic         load_i,
  input  logic [2:0]   mode_i,
  input  logic [30:0]  seed_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [2:0]   mode_o
);

  localparam logic [2:0]  RstMode  = prbs_mode_fix(DEF_MODE);
  localparam prbs_state_t RstState = prbs_seed(DEF_SEED, RstMode);

  logic [2:0]   mode_q, mode_d;
  prbs_state_t  state_q, state_d, state_step;
  logic [W-1:0] data_q, data_d, word, flip;
  logic         valid_q, valid_d;
  logic         adv;

  prbs_lfsr_core #(
    .W (W)
  ) u_core (
    .state      (state_q),
    .mode       (mode_q),
    .state_next (state_step),
    .word       (word)
  );

  assign adv = en_i & (~valid_q | ready_i) & ~load_i;

  // Output-only inversion; the LFSR state never sees it.
  always_comb begin
    flip = {W{INVERT}};
`ifdef PRBS_ERR_INJECT_EN
    flip[0] = flip[0] ^ inj_i;
`endif
  end

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      mode_d  = prbs_mode_fix(mode_i);
      state_d = prbs_seed(seed_i, mode_d);
      valid_d = 1'b0;
    end else if (adv) begin
      state_d = state_step;
      data_d  = word ^ flip;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= RstMode;
      state_q <= RstState;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign mode_o  = mode_q;

endmodule
